temp_ramp_ctrl: RTL and testbench

- Sequencer for the temp_register datapath.
- On start it loads the temperature error (measured − setpoint) into the register.
- It then issues paced increment/decrement pulses, steered by the register's sign/zero flags, until the register reads zero.
- It reports heat/cool activity, step count and completion to the top-level lab controller.

---
 rtl/temp_ramp_pkg.sv | 33 +++
 rtl/step_pacer.sv | 31 +++
 rtl/temp_ramp_ctrl.sv | 153 +++++++++++++++
 tb/tb_temp_ramp_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_ramp_pkg.sv
// Shared types and constants for the temperature ramp sequencer.
// Holds the FSM state encoding, error saturation limits and the error helper.
package temp_ramp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EVAL,
        WAIT,
        STEP,
        DONE
    } state_t;

    localparam int ERR_MAX = 127;
    localparam int ERR_MIN = -128;
    localparam logic [7:0] STEP_CNT_MAX = 8'd255;

    // measured - setpoint in 9 bits, clamped into the 8-bit signed range
    function automatic logic [7:0] sat_err(
        input logic signed [7:0] a,
        input logic signed [7:0] b
    );
        logic signed [8:0] d;
        d = {a[7], a} - {b[7], b};
        if (d > 9'(ERR_MAX)) begin
            return 8'(ERR_MAX);
        end else if (d < 9'(ERR_MIN)) begin
            return 8'(ERR_MIN);
        end
        return d[7:0];
    endfunction

endpackage

// File: rtl/step_pacer.sv
// Down-counter that paces step pulses: loaded with STEP_DIV, ticks on expiry.
// Ports: clk, reset_n, clear (cancel), load, enable (in WAIT) -> tick.
module step_pacer #(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic load,
    input  logic enable,
    output logic tick
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 8'd0;
        end else if (clear) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= 8'(STEP_DIV);
        end else if (enable && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    // last of the STEP_DIV wait cycles
    assign tick = enable && (cnt == 8'd1);

endmodule

// File: rtl/temp_ramp_ctrl.sv
// Ramp sequencer: loads the temperature error, then paces inc/dec strobes
// until the register reads zero. Optional TEMP_RAMP_TIMEOUT_EN adds a
// MAX_STEPS limit and a timeout pulse output.
// Ports: start/cancel control, measured/setpoint, register flags in;
// load/increment/decrement/data to the register; heat/cool/busy/done/
// step_count status out.
module temp_ramp_ctrl
    import temp_ramp_pkg::*;
#(
    parameter int STEP_DIV = 4
`ifdef TEMP_RAMP_TIMEOUT_EN
    ,
    parameter int MAX_STEPS = 200
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              cancel,
    input  logic signed [7:0] measured,
    input  logic signed [7:0] setpoint,
    input  logic              negative,
    input  logic              positive,
    input  logic              zero,
    output logic              load,
    output logic              increment,
    output logic              decrement,
    output logic [7:0]        data,
    output logic              heat,
    output logic              cool,
    output logic              busy,
    output logic              done,
`ifdef TEMP_RAMP_TIMEOUT_EN
    output logic              timeout,
`endif
    output logic [7:0]        step_count
);

    state_t state;
    state_t next_state;
    logic   tick;
    logic   limit;

`ifdef TEMP_RAMP_TIMEOUT_EN
    assign limit = (step_count >= 8'(MAX_STEPS));
`else
    assign limit = 1'b0;
`endif

    step_pacer #(
        .STEP_DIV(STEP_DIV)
    ) u_pacer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (cancel),
        .load   (state == EVAL),
        .enable (state == WAIT),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (cancel) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE: if (start) next_state = LOAD;
                LOAD: next_state = EVAL;
                EVAL: begin
                    if (zero) begin
                        next_state = DONE;
                    end else if (limit) begin
                        next_state = IDLE;
                    end else if (negative || positive) begin
                        next_state = WAIT;
                    end
                end
                WAIT: if (tick) next_state = STEP;
                STEP: next_state = EVAL;
                DONE: next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        load      = (state == LOAD);
        increment = (state == STEP) && heat;
        decrement = (state == STEP) && cool;
        done      = (state == DONE);
        busy      = (state != IDLE);
    end

    // direction is re-latched from the flags on every EVAL
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data       <= 8'd0;
            step_count <= 8'd0;
            heat       <= 1'b0;
            cool       <= 1'b0;
`ifdef TEMP_RAMP_TIMEOUT_EN
            timeout    <= 1'b0;
`endif
        end else begin
`ifdef TEMP_RAMP_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            if (cancel) begin
                heat <= 1'b0;
                cool <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            data       <= sat_err(measured, setpoint);
                            step_count <= 8'd0;
                        end
                    end
                    EVAL: begin
                        if (zero || limit) begin
                            heat <= 1'b0;
                            cool <= 1'b0;
`ifdef TEMP_RAMP_TIMEOUT_EN
                            timeout <= !zero;
`endif
                        end else if (negative) begin
                            heat <= 1'b1;
                            cool <= 1'b0;
                        end else if (positive) begin
                            heat <= 1'b0;
                            cool <= 1'b1;
                        end
                    end
                    STEP: begin
                        if (step_count != STEP_CNT_MAX) begin
                            step_count <= step_count + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_temp_ramp_ctrl.sv
// Self-checking bench for temp_ramp_ctrl: timeline model of each ramp,
// a register model driving the flags, and random plus directed ramps.
module tb_temp_ramp_ctrl;

    localparam int D = 4;
`ifdef TEMP_RAMP_TIMEOUT_EN
    localparam int MAXS = 2;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic cancel = 1'b0;
    logic signed [7:0] measured = 8'sd0;
    logic signed [7:0] setpoint = 8'sd0;
    logic negative, positive, zero;
    logic load, increment, decrement, heat, cool, busy, done;
    logic [7:0] data, step_count;
`ifdef TEMP_RAMP_TIMEOUT_EN
    logic timeout;
`endif

    always #5 clk = ~clk;

    temp_ramp_ctrl #(
        .STEP_DIV(D)
`ifdef TEMP_RAMP_TIMEOUT_EN
        ,
        .MAX_STEPS(MAXS)
`endif
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .cancel    (cancel),
        .measured  (measured),
        .setpoint  (setpoint),
        .negative  (negative),
        .positive  (positive),
        .zero      (zero),
        .load      (load),
        .increment (increment),
        .decrement (decrement),
        .data      (data),
        .heat      (heat),
        .cool      (cool),
        .busy      (busy),
        .done      (done),
`ifdef TEMP_RAMP_TIMEOUT_EN
        .timeout   (timeout),
`endif
        .step_count(step_count)
    );

    // the temp_register the controller steers
    int reg_val;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) reg_val <= 0;
        else if (load) reg_val <= int'($signed(data));
        else if (increment) reg_val <= reg_val + 1;
        else if (decrement) reg_val <= reg_val - 1;
    end
    assign negative = (reg_val < 0);
    assign positive = (reg_val >= 0);
    assign zero     = (reg_val == 0);

    int total = 0;
    int bad = 0;

    // model state
    int m_err = 0;
    int m_cancel = 1 << 30;
    int m_t = 0;
    bit m_active = 1'b0;
    bit m_pending = 1'b0;
    bit chk_en = 1'b0;
    int idle_data = 0;
    int idle_count = 0;

    // observers
    int done_at, to_at, inc_n, dec_n;
    bit heat_seen, cool_seen;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0d @%0t)",
                     nm, act, exp, m_t, $time);
        end
    endtask

    function automatic int sat(input int e);
        if (e > 127) return 127;
        if (e < -128) return -128;
        return e;
    endfunction

    function automatic int n_steps(input int err);
        int e;
        e = (err < 0) ? -err : err;
`ifdef TEMP_RAMP_TIMEOUT_EN
        if (e > MAXS) e = MAXS;
`endif
        return e;
    endfunction

    function automatic bit to_hit(input int err);
`ifdef TEMP_RAMP_TIMEOUT_EN
        return ((err < 0) ? -err : err) > MAXS;
`else
        return (err != err);
`endif
    endfunction

    // cycle of the done (or timeout) pulse, counting LOAD as cycle 1
    function automatic int t_end(input int err);
        return 3 + n_steps(err) * (D + 2);
    endfunction

    // step strobes issued in cycles before x; step k sits at 1+k*(D+2)
    function automatic int steps_by(input int x, input int err);
        int k;
        if (x < 2) return 0;
        k = (x - 2) / (D + 2);
        return (k > n_steps(err)) ? n_steps(err) : k;
    endfunction

    always @(posedge clk) begin
        int te, stop;
        te = t_end(m_err);
        stop = (m_cancel < te) ? m_cancel : te;
        if (m_pending) begin
            m_pending = 1'b0;
            m_active = 1'b1;
            m_t = 1;
        end else if (m_active) begin
            if (m_t >= stop + 2) begin
                m_active = 1'b0;
                idle_data = m_err & 255;
                idle_count = steps_by((m_cancel < te) ? m_cancel : te + 1, m_err);
            end else begin
                m_t++;
            end
        end
    end

    always @(negedge clk) begin
        int tt, te, x;
        bit live, stp, to;
        int e_load, e_inc, e_dec, e_heat, e_cool, e_busy, e_done, e_to;
        int e_data, e_cnt;
        e_load = 0; e_inc = 0; e_dec = 0; e_heat = 0; e_cool = 0;
        e_busy = 0; e_done = 0; e_to = 0;
        e_data = idle_data;
        e_cnt = idle_count;
        if (chk_en) begin
            if (m_active) begin
                tt = m_t;
                te = t_end(m_err);
                to = to_hit(m_err);
                live = (tt >= 1) && (tt <= m_cancel) && (to ? tt < te : tt <= te);
                x = (tt < m_cancel) ? tt : m_cancel;
                e_data = m_err & 255;
                e_cnt = steps_by(x, m_err);
                e_busy = int'(live);
                e_load = int'(live && tt == 1);
                stp = live && tt >= D + 3 && (tt - 1) % (D + 2) == 0 && tt < te;
                e_inc = int'(stp && m_err < 0);
                e_dec = int'(stp && m_err > 0);
                e_heat = int'(live && tt >= 3 && tt < te && m_err < 0);
                e_cool = int'(live && tt >= 3 && tt < te && m_err > 0);
                e_done = int'(live && tt == te && !to);
                e_to = int'(tt == te && to && m_cancel >= te);
                if (done) done_at = tt;
                if (increment) inc_n++;
                if (decrement) dec_n++;
                if (heat) heat_seen = 1'b1;
                if (cool) cool_seen = 1'b1;
`ifdef TEMP_RAMP_TIMEOUT_EN
                if (timeout) to_at = tt;
`endif
            end
            check("load", int'(load), e_load);
            check("increment", int'(increment), e_inc);
            check("decrement", int'(decrement), e_dec);
            check("heat", int'(heat), e_heat);
            check("cool", int'(cool), e_cool);
            check("busy", int'(busy), e_busy);
            check("done", int'(done), e_done);
            check("data", int'(data), e_data);
            check("step_count", int'(step_count), e_cnt);
            check("one_strobe", int'(load) + int'(increment) + int'(decrement) <= 1, 1);
`ifdef TEMP_RAMP_TIMEOUT_EN
            check("timeout", int'(timeout), e_to);
`else
            if (e_to != 0) check("timeout_model", e_to, 0);
`endif
        end
    end

    task automatic clr_obs();
        done_at = -1;
        to_at = -1;
        inc_n = 0;
        dec_n = 0;
        heat_seen = 1'b0;
        cool_seen = 1'b0;
    endtask

    // c: cancel cycle (0 = none); bs: extra start while busy (0 = none)
    task automatic ramp(input int m, input int s, input int c, input int bs);
        int cyc;
        clr_obs();
        @(posedge clk);
        #1;
        measured = 8'(m);
        setpoint = 8'(s);
        start = 1'b1;
        m_err = sat(m - s);
        m_cancel = (c == 0) ? (1 << 30) : c;
        m_pending = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while ((m_active || m_pending) && cyc < 3000) begin
            measured = 8'($urandom);
            setpoint = 8'($urandom);
            start = (cyc == bs) || (c != 0 && cyc == c);
            cancel = (c != 0 && cyc == c);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        cancel = 1'b0;
        if (m_active) begin
            check("ramp_bound", 0, 1);
            m_active = 1'b0;
        end
    endtask

    initial begin
        clr_obs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_step_count", int'(step_count), 0);
        check("rst_data", int'(data), 0);
        check("rst_outs", int'({load, increment, decrement, heat, cool, done}), 0);
        reset_n = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);

        // cool ramp
        ramp(25, 20, 0, 0);
        check("cool_data", int'(data), 5);
        check("cool_heat_seen", int'(heat_seen), 0);
        check("cool_cool_seen", int'(cool_seen), 1);
`ifdef TEMP_RAMP_TIMEOUT_EN
        check("cool_to_at", to_at, 15);
        check("cool_done_at", done_at, -1);
        check("cool_steps", dec_n, 2);
        check("cool_count", int'(step_count), 2);
`else
        check("cool_done_at", done_at, 33);
        check("cool_steps", dec_n, 5);
        check("cool_count", int'(step_count), 5);
`endif

        // heat ramp
        ramp(-3, 0, 0, 0);
        check("heat_data", int'(data), 8'hFD);
        check("heat_cool_seen", int'(cool_seen), 0);
        check("heat_heat_seen", int'(heat_seen), 1);
`ifdef TEMP_RAMP_TIMEOUT_EN
        check("heat_steps", inc_n, 2);
        check("heat_count", int'(step_count), 2);
`else
        check("heat_done_at", done_at, 21);
        check("heat_steps", inc_n, 3);
        check("heat_count", int'(step_count), 3);
`endif

        // zero error
        ramp(17, 17, 0, 0);
        check("zero_done_at", done_at, 3);
        check("zero_strobes", inc_n + dec_n, 0);
        check("zero_count", int'(step_count), 0);

        // saturation both ways
        ramp(100, -100, 0, 0);
        check("sat_hi_data", int'(data), 8'h7F);
        check("sat_hi_cool", int'(cool_seen), 1);
        ramp(-100, 100, 0, 0);
        check("sat_lo_data", int'(data), 8'h80);
        check("sat_lo_heat", int'(heat_seen), 1);

        // cancel (with start) during the second WAIT
        ramp(25, 20, 10, 0);
        check("cancel_count", int'(step_count), 1);
        check("cancel_no_done", done_at, -1);

        // cancel and start together in IDLE
        @(posedge clk);
        #1;
        start = 1'b1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cancel = 1'b0;
        check("idle_cancel_start", int'(busy), 0);

        // asynchronous reset in STEP
        chk_en = 1'b0;
        @(posedge clk);
        #1;
        measured = 8'sd25;
        setpoint = 8'sd20;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 0; n < 50 && !decrement; n++) begin
            @(posedge clk);
            #1;
        end
        check("rst_step_seen", int'(decrement), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_outs", int'({load, increment, decrement, heat, cool, busy, done}), 0);
        check("arst_data", int'(data), 0);
        check("arst_count", int'(step_count), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle_data = 0;
        idle_count = 0;
        @(posedge clk);
        #1;
        check("arst_idle", int'(busy), 0);
        chk_en = 1'b1;

        // random ramps
        for (int i = 0; i < 30; i++) begin
            int m, s, e, te, c, bs, lim;
            if ($urandom_range(0, 5) == 0) begin
                m = int'($urandom_range(0, 255)) - 128;
                s = int'($urandom_range(0, 255)) - 128;
            end else begin
                m = int'($urandom_range(0, 60)) - 30;
                s = int'($urandom_range(0, 60)) - 30;
            end
            e = sat(m - s);
            te = t_end(e);
            c = 0;
            bs = 0;
            if ($urandom_range(0, 2) == 0) c = int'($urandom_range(1, te - 1));
            lim = (c != 0) ? c : (to_hit(e) ? te - 1 : te);
            if ($urandom_range(0, 1) == 0) bs = int'($urandom_range(1, lim));
            ramp(m, s, c, bs);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
